// File: rtl/rom_sequencer_pkg.sv
// rtl/rom_sequencer_pkg.sv - shared state encoding and default table contents
package rom_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // First eight entries are a fixed pattern; beyond that an entry equals its index.
   function automatic logic [31:0] rom_entry(input logic [31:0] idx);
      logic [31:0] v;
      case (idx)
         32'd0:   v = 32'h0;
         32'd1:   v = 32'hC;
         32'd2:   v = 32'h6;
         32'd3:   v = 32'h7;
         32'd4:   v = 32'h8;
         32'd5:   v = 32'h1;
         32'd6:   v = 32'hD;
         32'd7:   v = 32'hE;
         default: v = idx;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/rom_table_lut.sv
// rtl/rom_table_lut.sv - combinational table lookup, entry truncated or zero-extended to DATA_W
module rom_table_lut
   import rom_sequencer_pkg::*;
#(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 3
) (
   input  logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data
);

   assign data = DATA_W'(rom_entry(32'(addr)));

endmodule

// File: rtl/rom_sequencer.sv
// rtl/rom_sequencer.sv - plays a captured address range of the table over a valid/ready stream
module rom_sequencer
   import rom_sequencer_pkg::*;
#(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic              loop_en,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] end_addr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] start_q, start_nxt;
   logic [ADDR_W-1:0] end_q, end_nxt;
   logic [ADDR_W-1:0] addr_q, addr_nxt;
   logic [ADDR_W-1:0] addr_inc;
   logic              valid_nxt, last_nxt, load;
   logic [DATA_W-1:0] lut_data;

   assign addr_inc = addr_q + 1'b1;

   // The lookup sits on the next address so the entry is registered on the same edge.
   rom_table_lut #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
   ) u_lut (
      .addr(addr_nxt),
      .data(lut_data)
   );

   always_comb begin
      state_nxt = state;
      start_nxt = start_q;
      end_nxt   = end_q;
      addr_nxt  = addr_q;
      valid_nxt = out_valid;
      last_nxt  = out_last;
      load      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               start_nxt = start_addr;
               end_nxt   = end_addr;
               addr_nxt  = start_addr;
               last_nxt  = (start_addr == end_addr);
               valid_nxt = 1'b1;
               load      = 1'b1;
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            // Abort wins over a coincident handshake; that entry is simply consumed.
            if (stop) begin
               valid_nxt = 1'b0;
               state_nxt = ST_IDLE;
            end else if (out_valid && out_ready) begin
               if (!out_last) begin
                  addr_nxt = addr_inc;
                  last_nxt = (addr_inc == end_q);
                  load     = 1'b1;
               end else if (loop_en) begin
                  addr_nxt = start_q;
                  last_nxt = (start_q == end_q);
                  load     = 1'b1;
               end else begin
                  valid_nxt = 1'b0;
                  state_nxt = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
            valid_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         start_q   <= '0;
         end_q     <= '0;
         addr_q    <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
      end else begin
         state     <= state_nxt;
         start_q   <= start_nxt;
         end_q     <= end_nxt;
         addr_q    <= addr_nxt;
         out_valid <= valid_nxt;
         out_last  <= last_nxt;
         if (load) begin
            out_data <= lut_data;
         end
      end
   end

   assign out_addr = addr_q;
   assign busy     = (state != ST_IDLE);
   assign done     = (state == ST_DONE);

endmodule

// File: tb/tb_rom_sequencer.sv
// tb/tb_rom_sequencer.sv - self-checking bench for rom_sequencer (default and 8/4 parameter sets)
module tb_rom_sequencer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       start, stop, loop_en, out_ready;
   logic [2:0] start_addr, end_addr;
   logic       out_valid, out_last, busy, done;
   logic [3:0] out_data;
   logic [2:0] out_addr;

   logic       start8, stop8, loop_en8, out_ready8;
   logic [3:0] start_addr8, end_addr8;
   logic       out_valid8, out_last8, busy8, done8;
   logic [7:0] out_data8;
   logic [3:0] out_addr8;

   rom_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
      .start_addr(start_addr), .end_addr(end_addr), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
      .out_last(out_last), .busy(busy), .done(done)
   );

   rom_sequencer #(.DATA_W(8), .ADDR_W(4)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .stop(stop8), .loop_en(loop_en8),
      .start_addr(start_addr8), .end_addr(end_addr8), .out_valid(out_valid8),
      .out_ready(out_ready8), .out_data(out_data8), .out_addr(out_addr8),
      .out_last(out_last8), .busy(busy8), .done(done8)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_entry(input int idx, input int w);
      int v;
      case (idx)
         0: v = 0;   1: v = 12;  2: v = 6;   3: v = 7;
         4: v = 8;   5: v = 1;   6: v = 13;  7: v = 14;
         default: v = idx;
      endcase
      return 32'(v) & ((32'd1 << w) - 32'd1);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_oneshot(input logic [2:0] s, input logic [2:0] e, input bit rnd,
                              output int nbeats, output logic [3:0] first_d, output logic [3:0] last_d);
      int len, idx, cyc, a;
      len = ((int'(e) - int'(s)) & 7) + 1;
      idx = 0;
      cyc = 0;
      first_d = '0;
      last_d = '0;
      start_addr = s;
      end_addr = e;
      loop_en = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      while (idx < len && cyc < 400) begin
         a = (int'(s) + idx) & 7;
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         chk("beat_valid", out_valid, 1);
         chk("beat_addr", out_addr, a);
         chk("beat_data", out_data, ref_entry(a, 4));
         chk("beat_last", out_last, (idx == len - 1));
         chk("beat_busy_done", {busy, done}, 2'b10);
         if (idx == 0) first_d = out_data;
         last_d = out_data;
         if (out_ready) idx++;
         step();
         cyc++;
      end
      if (cyc >= 400) chk("oneshot_timeout", 0, 1);
      nbeats = idx;
      chk("done_pulse", {out_valid, busy, done}, 3'b011);
      step();
      chk("back_idle", {out_valid, busy, done}, 3'b000);
   endtask

   task automatic run8(input logic [3:0] s, input logic [7:0] exp_d);
      start_addr8 = s;
      end_addr8 = s;
      out_ready8 = 1'b1;
      start8 = 1'b1;
      step();
      start8 = 1'b0;
      chk("p8_valid", out_valid8, 1);
      chk("p8_data", out_data8, exp_d);
      chk("p8_addr", out_addr8, s);
      chk("p8_last", out_last8, 1);
      step();
      chk("p8_done", {out_valid8, done8}, 2'b01);
      step();
      chk("p8_idle", {busy8, done8}, 2'b00);
   endtask

   typedef struct {
      logic [2:0] s;
      logic [2:0] e;
      int         len;
      logic [3:0] first;
      logic [3:0] last;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int n, exp_len;
      logic [3:0] f, l;
      logic [2:0] rs, re;

      vecs[0] = '{3'd1, 3'd4, 4, 4'hC, 4'h8};
      vecs[1] = '{3'd6, 3'd1, 4, 4'hD, 4'hC};
      vecs[2] = '{3'd3, 3'd3, 1, 4'h7, 4'h7};
      vecs[3] = '{3'd0, 3'd7, 8, 4'h0, 4'hE};
      vecs[4] = '{3'd7, 3'd0, 2, 4'hE, 4'h0};

      start = 0; stop = 0; loop_en = 0; out_ready = 0; start_addr = 0; end_addr = 0;
      start8 = 0; stop8 = 0; loop_en8 = 0; out_ready8 = 0; start_addr8 = 0; end_addr8 = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_outputs", {out_valid, out_data, out_addr, out_last, busy, done}, 0);
      chk("rst_outputs8", {out_valid8, out_data8, out_addr8, out_last8, busy8, done8}, 0);
      rst_n = 1'b1;
      step();

      // Table-driven one-shot ranges, ready held high.
      for (int i = 0; i < 5; i++) begin
         run_oneshot(vecs[i].s, vecs[i].e, 1'b0, n, f, l);
         chk("vec_len", n, vecs[i].len);
         chk("vec_first", f, vecs[i].first);
         chk("vec_last", l, vecs[i].last);
      end

      // Random ranges with random backpressure.
      for (int i = 0; i < 20; i++) begin
         rs = 3'($urandom);
         re = 3'($urandom);
         exp_len = ((int'(re) - int'(rs)) & 7) + 1;
         run_oneshot(rs, re, 1'b1, n, f, l);
         chk("rand_len", n, exp_len);
         chk("rand_first", f, ref_entry(int'(rs), 4));
         chk("rand_last", l, ref_entry(int'(re), 4));
      end

      // Continuous loop, stray start ignored, then loop_en dropped on a last beat.
      start_addr = 3'd2; end_addr = 3'd3; loop_en = 1'b1; out_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 6; k++) begin
         chk("loop_valid", out_valid, 1);
         chk("loop_data", out_data, (k % 2) ? 32'h7 : 32'h6);
         chk("loop_last", out_last, k % 2);
         start = (k == 2);
         start_addr = (k == 2) ? 3'd5 : 3'd2;
         if (k == 5) loop_en = 1'b0;
         step();
      end
      start = 1'b0;
      chk("loop_end_done", {out_valid, busy, done}, 3'b011);
      step();
      chk("loop_end_idle", {busy, done}, 2'b00);

      // Stop together with a handshake on the second entry.
      start_addr = 3'd1; end_addr = 3'd4; out_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("stop_beat0", out_addr, 1);
      step();
      chk("stop_beat1", out_addr, 2);
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("stop_cleared", {out_valid, busy, done}, 3'b000);
      step();
      chk("stop_no_done", {busy, done}, 2'b00);
      start_addr = 3'd0; end_addr = 3'd0;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("restart_beat", {out_valid, out_addr, out_last}, {1'b1, 3'd0, 1'b1});
      step();
      chk("restart_done", done, 1);
      step();

      // Asynchronous reset in the middle of a run.
      start_addr = 3'd0; end_addr = 3'd7; out_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      #2 rst_n = 1'b0;
      #1;
      chk("midrun_reset", {out_valid, out_data, out_addr, out_last, busy, done}, 0);
      rst_n = 1'b1;
      step();
      chk("post_reset_idle", {out_valid, busy, done}, 0);

      // Wider parameter set.
      run8(4'd5, 8'h01);
      run8(4'd12, 8'h0C);
      run8(4'd9, 8'h09);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rom_sequencer.md
# rom_sequencer

Parametrised table-playback block: holds a constant lookup table of `DEPTH` entries of `DATA_W` bits and streams a programmed address range out over a valid/ready handshake. It supports one-shot and continuous-loop playback, wrap-around ranges and abort. It sits between control logic that issues `start` and any consumer of a fixed pattern stream, such as display, DAC or test-pattern paths. The output is registered and sustains one entry per cycle while `out_ready` is held high.

## Interface
- `DATA_W`, default 4: entry width in bits.
- `ADDR_W`, default 3: address width; `DEPTH = 2**ADDR_W`.
- One clock; reset is asynchronous and active-low.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle request to begin playback; honoured only in IDLE.
- `stop` in 1: abort playback; honoured in RUN.
- `loop_en` in 1: restart at the captured start address after the last entry; sampled live at each end-of-range handshake.
- `start_addr` in ADDR_W: first address; captured on an accepted `start`.
- `end_addr` in ADDR_W: last address; captured on an accepted `start`.
- `out_valid` out 1: `out_data`, `out_addr` and `out_last` are valid.
- `out_ready` in 1: consumer accepts the current entry.
- `out_data` out DATA_W: table entry.
- `out_addr` out ADDR_W: address of `out_data`.
- `out_last` out 1: current entry is at the captured `end_addr`.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle pulse when a one-shot pass completes.

## Operation
- Table contents are constant. Entries 0..7 are 0x0, 0xC, 0x6, 0x7, 0x8, 0x1, 0xD, 0xE.
- Each entry is zero-extended or truncated to `DATA_W`. Entries at index 8 and above equal the index, truncated to `DATA_W`.
- The FSM has three states:
  - IDLE: `start` captures the range, loads the entry at `start_addr` into the output register, asserts `out_valid` and moves to RUN.
  - RUN: a handshake (`out_valid & out_ready`) advances the address.
    - If the accepted entry is not last, the next address is the current address + 1, modulo `DEPTH`, and that entry is loaded on the same edge.
    - If it is last and `loop_en` is 1, the next address is the captured start and the FSM stays in RUN.
    - If it is last and `loop_en` is 0, `out_valid` is cleared and the FSM moves to DONE.
  - DONE: `done` is 1 for exactly one cycle, then the FSM returns to IDLE.
- Range length is `((end - start) mod DEPTH) + 1`. `end < start` wraps through `DEPTH-1` to 0. `end == start` plays a single entry.
- Without a handshake, all outputs hold stable while `out_valid` is 1.
- `stop` in RUN clears `out_valid` at the next edge and returns the FSM to IDLE with no `done` pulse.
  - If `stop` and a handshake occur in the same cycle, the entry counts as consumed and `stop` still wins.
- `start` outside IDLE is ignored. `start` during the DONE cycle is ignored.
- `stop` in IDLE or DONE is ignored.

## Timing
- Reset values: the FSM is IDLE and every output (`out_valid`, `out_data`, `out_addr`, `out_last`, `busy`, `done`) is 0.
- An `rst_n` assertion mid-playback clears all state immediately. No `done` is produced.
- Latency from `start` to `out_valid` is 1 cycle.
- Throughput is 1 entry per cycle with `out_ready` held at 1, including across the loop boundary, which adds no bubble.
- `done` rises 1 cycle after the final handshake. `busy` falls 2 cycles after it.
- There is no combinational path from any input to any output; all outputs are registered.

## Structure
- Package `rom_sequencer_pkg` holds:
  - the state enum (IDLE, RUN, DONE);
  - the function `rom_entry(idx)`, which returns the default table value for an index.
- Sub-module `rom_table_lut` is a purely combinational, parametrised lookup: address in, `DATA_W` entry out, built from `rom_entry`.
- `rom_sequencer` contains the FSM, the address counter and the output register.

## Test plan
- One-shot, defaults, start=1, end=4, ready held high: data 0xC, 0x6, 0x7, 0x8 on consecutive cycles; `out_last` on 0x8; `done` pulses once; `busy` returns to 0.
- Wrap-around, start=6, end=1: addresses 6, 7, 0, 1 with data 0xD, 0xE, 0x0, 0xC.
- Loop, start=2, end=3, `loop_en`=1: 0x6, 0x7, 0x6, 0x7… with no gap. Dropping `loop_en` before a last handshake ends playback after that 0x7 with `done`.
- Backpressure, `out_ready` toggled 1/0 at random: outputs stay stable while not ready and no entry is skipped or duplicated.
- Stop and reset: `stop` asserted together with a handshake on the second entry gives `out_valid` 0 next cycle, no `done`, and `start` accepted again. `rst_n` low mid-run clears all outputs immediately.
- Parameters `DATA_W`=8, `ADDR_W`=4: entry 5 reads 0x01 and entry 12 reads 0x0C. A single-entry range (start=end=9) gives one beat with `out_last` set.
